l1_req_sequencer: RTL
=====================

Name: l1_req_sequencer

Overview:
Synthesizable, parametrised request sequencer that replays a loaded table of L1 request vectors into NUM_L1 L1 cache request ports. It is the hardware successor of the file-driven bench stimulus. Vectors sharing a group tag are issued concurrently, and each port's valid is dropped individually on its ready. The block adds a per-group timeout, duplicate-port group splitting and per-port response capture. It sits between a vector loader (bench or debug host) and the L1 request side of top.

Parameters:
NUM_L1, 4, number of L1 request ports
ADDR_W, 32, request address width
DATA_W, 32, request/response data width
DEPTH, 64, vector table entries (power of two)
TAG_W, 16, group tag width
TIMEOUT, 50, max wait cycles per group
GAP_CYCLES, 2, idle cycles between groups

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
load_en  in  1  write vector entry this cycle (ignored unless IDLE/DONE)
load_idx  in  log2(DEPTH)  entry index
load_addr  in  ADDR_W  entry address
load_write  in  1  entry op: 1 = write, 0 = read
load_l1  in  log2(NUM_L1)  target port
load_data  in  DATA_W  write data
load_tag  in  TAG_W  group tag (loader guarantees nondecreasing order)
num_vec  in  log2(DEPTH)+1  valid entry count, sampled on start
start  in  1  begin replay (pulse, honoured in IDLE/DONE only)
l1_valid  out  NUM_L1  per-port request valid
l1_mem_write  out  NUM_L1  per-port write flag
l1_data_adr  out  NUM_L1*ADDR_W  per-port address
l1_write_data  out  NUM_L1*DATA_W  per-port write data
l1_ready  in  NUM_L1  per-port completion
l1_read_data  in  NUM_L1*DATA_W  per-port read data
rsp_valid  out  NUM_L1  1-cycle pulse per completed request
rsp_data  out  NUM_L1*DATA_W  captured l1_read_data (writes: echoed write data)
busy  out  1  replay in progress
test_done  out  1  high in DONE until next start
timeout_err  out  1  sticky, cleared on start
vec_count  out  log2(DEPTH)+1  completed vectors

Behaviour:
- Reset: all outputs 0; state IDLE; ptr=0; table contents undefined (not reset).
- States: IDLE -> (start) GATHER -> WAIT -> GAP -> GATHER | DONE.
- start: latch num_vec; clear vec_count, timeout_err, test_done. num_vec=0 -> DONE next cycle.
- GATHER: on entry, group_tag := tag[ptr]. Then one entry per cycle: if ptr<num_vec, tag[ptr]==group_tag and port not yet in group mask, load that port's registers, set mask bit, ptr++. Otherwise -> WAIT. Duplicate port in one group closes the group; the remaining entries form a new group with the same tag.
- WAIT: l1_valid = mask, asserted from the first WAIT cycle. l1_ready is ignored in that first cycle and sampled from the second onward. On sampled l1_ready[i] with l1_valid[i]: l1_valid[i] low next cycle, rsp_valid[i] pulse same next cycle, rsp_data[i] captured, vec_count++. Simultaneous readies all complete in the same cycle; vec_count adds popcount.
- WAIT exit: all mask ports complete -> GAP. Wait counter reaches TIMEOUT -> timeout_err=1, all l1_valid low, no rsp for incomplete ports (not counted), -> GAP.
- GAP: GAP_CYCLES idle cycles, then GATHER if ptr<num_vec, else DONE.
- l1_mem_write/adr/write_data hold their values after valid drops until overwritten.
- busy = state not in {IDLE, DONE}.
- load_en while busy is ignored.
- start while busy is ignored.

Optional Feature:
LATENCY_STAT_EN:
- Defined: adds outputs rsp_latency (NUM_L1*16) and max_latency (16). rsp_latency[i] = cycles from first WAIT cycle to ready sample, valid with rsp_valid[i]. max_latency is the running maximum, cleared on start. Both saturate at 16'hFFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Single read: entry {0x0, R, L1=0, tag 0}, ready after 3 cycles, read_data 0xDEADBEEF -> rsp_valid[0] once, rsp_data[0]=0xDEADBEEF, vec_count=1, test_done.
- Concurrent group: 4 entries tag 5, ports 0-3, readies at cycles 2,2,4,7 -> all valids high together; ports 0,1 drop together, then 2, then 3; vec_count=4.
- Duplicate split: tags 0,0 both on L1=1 -> two sequential groups separated by GAP_CYCLES=2; valid never overlaps.
- Timeout: L1=2 never ready -> valid drops after 50 wait cycles, timeout_err=1, vec_count=0, next group still issues.
- Reset mid-WAIT: assert reset with valids high -> all outputs 0 immediately (async); start again replays from entry 0.
- LATENCY_STAT_EN: ready sampled on 4th WAIT cycle -> rsp_latency=3, max_latency=3.

Source files
------------

// File: rtl/l1_req_sequencer.sv
// l1_req_sequencer: replays a loaded table of L1 request vectors into NUM_L1
// L1 request ports. Consecutive entries sharing a tag form a group that is
// issued concurrently. A repeated port closes the group early, and the
// remaining entries form a new group with the same tag. Each port's valid
// drops individually on its ready. A group that is still incomplete after
// TIMEOUT wait cycles is abandoned and the sticky timeout_err flag is set.
//
// Optional feature macro: LATENCY_STAT_EN adds rsp_latency/max_latency.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   load_en/idx/addr/write/l1/data/tag
//                              table write port (honoured in IDLE/DONE only)
//   num_vec, start             entry count and replay start pulse
//   l1_valid/mem_write/data_adr/write_data
//                              per-port request outputs
//   l1_ready, l1_read_data     per-port completion inputs
//   rsp_valid, rsp_data        per-port completion pulse and captured data
//   busy, test_done, timeout_err, vec_count
//                              replay status
//   rsp_latency, max_latency   (LATENCY_STAT_EN only) wait-cycle statistics
module l1_req_sequencer #(
  parameter int NUM_L1     = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 64,
  parameter int TAG_W      = 16,
  parameter int TIMEOUT    = 50,
  parameter int GAP_CYCLES = 2
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      load_en,
  input  logic [$clog2(DEPTH)-1:0]                  load_idx,
  input  logic [ADDR_W-1:0]                         load_addr,
  input  logic                                      load_write,
  input  logic [((NUM_L1 > 1) ? $clog2(NUM_L1) : 1)-1:0] load_l1,
  input  logic [DATA_W-1:0]                         load_data,
  input  logic [TAG_W-1:0]                          load_tag,
  input  logic [$clog2(DEPTH):0]                    num_vec,
  input  logic                                      start,
  output logic [NUM_L1-1:0]                         l1_valid,
  output logic [NUM_L1-1:0]                         l1_mem_write,
  output logic [NUM_L1*ADDR_W-1:0]                  l1_data_adr,
  output logic [NUM_L1*DATA_W-1:0]                  l1_write_data,
  input  logic [NUM_L1-1:0]                         l1_ready,
  input  logic [NUM_L1*DATA_W-1:0]                  l1_read_data,
  output logic [NUM_L1-1:0]                         rsp_valid,
  output logic [NUM_L1*DATA_W-1:0]                  rsp_data,
  output logic                                      busy,
  output logic                                      test_done,
  output logic                                      timeout_err,
  output logic [$clog2(DEPTH):0]                    vec_count
`ifdef LATENCY_STAT_EN
  ,
  output logic [NUM_L1*16-1:0]                      rsp_latency,
  output logic [15:0]                               max_latency
`endif
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PORT_W = (NUM_L1 > 1) ? $clog2(NUM_L1) : 1;
  localparam logic [IDX_W:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_GATHER, S_WAIT, S_GAP, S_DONE} state_t;
  state_t state, state_next;

  // Vector table (not reset)
  logic [ADDR_W-1:0] tbl_addr  [DEPTH];
  logic              tbl_write [DEPTH];
  logic [PORT_W-1:0] tbl_l1    [DEPTH];
  logic [DATA_W-1:0] tbl_data  [DEPTH];
  logic [TAG_W-1:0]  tbl_tag   [DEPTH];

  logic [IDX_W:0]    ptr, num_vec_reg;
  logic [TAG_W-1:0]  group_tag;
  logic              gather_first;
  logic [NUM_L1-1:0] mask;
  logic [31:0]       wait_cnt, gap_cnt;

  logic [IDX_W-1:0]  ent_idx;
  logic [ADDR_W-1:0] ent_addr;
  logic              ent_write;
  logic [PORT_W-1:0] ent_l1;
  logic [DATA_W-1:0] ent_data;
  logic [TAG_W-1:0]  ent_tag, cur_tag;
  logic              ent_ok, take, more, gap_last, timeout_hit;
  logic [NUM_L1-1:0] load_sel, sample, pending;
  logic [IDX_W:0]    done_cnt;

  always_ff @(posedge clk) begin
    if (load_en && !busy) begin
      tbl_addr[load_idx]  <= load_addr;
      tbl_write[load_idx] <= load_write;
      tbl_l1[load_idx]    <= load_l1;
      tbl_data[load_idx]  <= load_data;
      tbl_tag[load_idx]   <= load_tag;
    end
  end

  // ptr wraps into a valid index when it equals DEPTH; ent_ok masks that case.
  assign ent_idx   = ptr[IDX_W-1:0];
  assign ent_addr  = tbl_addr[ent_idx];
  assign ent_write = tbl_write[ent_idx];
  assign ent_l1    = tbl_l1[ent_idx];
  assign ent_data  = tbl_data[ent_idx];
  assign ent_tag   = tbl_tag[ent_idx];

  assign ent_ok   = ptr < num_vec_reg;
  assign more     = ent_ok;
  // The first gather cycle adopts the entry's own tag as the group tag.
  assign cur_tag  = gather_first ? ent_tag : group_tag;
  assign take     = (state == S_GATHER) && ent_ok && (ent_tag == cur_tag) && !mask[ent_l1];
  assign load_sel = take ? (NUM_L1'(1) << ent_l1) : '0;

  // Ready is ignored in the first WAIT cycle.
  assign sample      = (state == S_WAIT && wait_cnt != 32'd0) ? (l1_ready & l1_valid) : '0;
  assign pending     = l1_valid & ~sample;
  assign timeout_hit = (state == S_WAIT) && (wait_cnt >= 32'(TIMEOUT - 1)) && (pending != '0);
  assign gap_last    = (GAP_CYCLES <= 1) || (gap_cnt >= 32'(GAP_CYCLES - 1));

  always_comb begin
    done_cnt = '0;
    for (int i = 0; i < NUM_L1; i++) begin
      done_cnt = done_cnt + {{IDX_W{1'b0}}, sample[i]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_next = (num_vec == '0) ? S_DONE : S_GATHER;
      S_GATHER:       if (!take) state_next = S_WAIT;
      S_WAIT:         if (pending == '0 || timeout_hit) state_next = S_GAP;
      S_GAP:          if (gap_last) state_next = more ? S_GATHER : S_DONE;
      default:        state_next = S_IDLE;
    endcase
  end

  assign busy      = (state == S_GATHER) || (state == S_WAIT) || (state == S_GAP);
  assign test_done = (state == S_DONE);

`ifdef LATENCY_STAT_EN
  logic [15:0] lat_val;
  assign lat_val = (wait_cnt > 32'h0000_FFFF) ? 16'hFFFF : wait_cnt[15:0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr          <= '0;
      num_vec_reg  <= '0;
      group_tag    <= '0;
      gather_first <= 1'b0;
      mask         <= '0;
      wait_cnt     <= '0;
      gap_cnt      <= '0;
      vec_count    <= '0;
      timeout_err  <= 1'b0;
`ifdef LATENCY_STAT_EN
      max_latency  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            num_vec_reg  <= num_vec;
            ptr          <= '0;
            vec_count    <= '0;
            timeout_err  <= 1'b0;
            mask         <= '0;
            gather_first <= 1'b1;
`ifdef LATENCY_STAT_EN
            max_latency  <= '0;
`endif
          end
        end
        S_GATHER: begin
          gather_first <= 1'b0;
          if (gather_first) group_tag <= ent_tag;
          if (take) begin
            mask <= mask | load_sel;
            ptr  <= ptr + PTR_ONE;
          end else begin
            wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          wait_cnt  <= wait_cnt + 32'd1;
          vec_count <= vec_count + done_cnt;
          if (timeout_hit) timeout_err <= 1'b1;
`ifdef LATENCY_STAT_EN
          if (sample != '0 && lat_val > max_latency) max_latency <= lat_val;
`endif
          if (state_next == S_GAP) begin
            mask         <= '0;
            gap_cnt      <= '0;
            gather_first <= 1'b1;
          end
        end
        S_GAP: gap_cnt <= gap_cnt + 32'd1;
        default: ;
      endcase
    end
  end

  // Per-port request and response registers
  logic              valid_reg     [NUM_L1];
  logic              wr_reg        [NUM_L1];
  logic [ADDR_W-1:0] adr_reg       [NUM_L1];
  logic [DATA_W-1:0] wdata_reg     [NUM_L1];
  logic              rsp_valid_reg [NUM_L1];
  logic [DATA_W-1:0] rsp_data_reg  [NUM_L1];
`ifdef LATENCY_STAT_EN
  logic [15:0]       lat_reg       [NUM_L1];
`endif

  genvar gi;
  for (gi = 0; gi < NUM_L1; gi++) begin : g_port
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid_reg[gi]     <= 1'b0;
        wr_reg[gi]        <= 1'b0;
        adr_reg[gi]       <= '0;
        wdata_reg[gi]     <= '0;
        rsp_valid_reg[gi] <= 1'b0;
        rsp_data_reg[gi]  <= '0;
`ifdef LATENCY_STAT_EN
        lat_reg[gi]       <= '0;
`endif
      end else begin
        rsp_valid_reg[gi] <= 1'b0;
        if (load_sel[gi]) begin
          wr_reg[gi]    <= ent_write;
          adr_reg[gi]   <= ent_addr;
          wdata_reg[gi] <= ent_data;
        end
        if (state == S_GATHER && !take) begin
          valid_reg[gi] <= mask[gi];
        end else if (sample[gi]) begin
          valid_reg[gi]     <= 1'b0;
          rsp_valid_reg[gi] <= 1'b1;
          // Writes echo their own data as the response.
          rsp_data_reg[gi]  <= wr_reg[gi] ? wdata_reg[gi] : l1_read_data[gi*DATA_W +: DATA_W];
`ifdef LATENCY_STAT_EN
          lat_reg[gi]       <= lat_val;
`endif
        end else if (timeout_hit) begin
          valid_reg[gi] <= 1'b0;
        end
      end
    end

    assign l1_valid[gi]                        = valid_reg[gi];
    assign l1_mem_write[gi]                    = wr_reg[gi];
    assign l1_data_adr[gi*ADDR_W +: ADDR_W]    = adr_reg[gi];
    assign l1_write_data[gi*DATA_W +: DATA_W]  = wdata_reg[gi];
    assign rsp_valid[gi]                       = rsp_valid_reg[gi];
    assign rsp_data[gi*DATA_W +: DATA_W]       = rsp_data_reg[gi];
`ifdef LATENCY_STAT_EN
    assign rsp_latency[gi*16 +: 16]            = lat_reg[gi];
`endif
  end

endmodule
